// File: rtl/piso_tx_pkg.sv
// Shared definitions for the serial link: FSM state encoding and line levels.
// The receiver imports the same line constants so both ends agree on framing.
package piso_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last cycle.
// clear holds the count at zero so the first bit period starts aligned.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH data bits LSB-first,
// stop bit, each held CLKS_PER_BIT cycles. All outputs come straight from flops.
//
// state | meaning
// IDLE  | line high, ready for a word
// START | driving the start bit
// DATA  | driving shift_reg[0], one bit per tick
// STOP  | driving the stop bit
module piso_tx
   import piso_tx_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             tx,
   output logic             busy
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shift_reg, shifted;
   logic [IW-1:0]    idx;
   logic             tx_nxt, load, shift_en, tick, timer_clear;

   assign shifted     = shift_reg >> 1;
   assign timer_clear = (state == IDLE);

   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (timer_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tx        <= LINE_IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         shift_reg <= '0;
         idx       <= '0;
      end else begin
         state    <= state_nxt;
         tx       <= tx_nxt;
         in_ready <= (state_nxt == IDLE);
         busy     <= (state_nxt != IDLE);
         if (load) begin
            shift_reg <= in_data;
            idx       <= '0;
         end else if (shift_en) begin
            shift_reg <= shifted;
            idx       <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
         end
      end
   end

   // tx is registered, so the level for the next cycle is chosen here.
   always_comb begin
      state_nxt = state;
      tx_nxt    = tx;
      load      = 1'b0;
      shift_en  = 1'b0;
      unique case (state)
         IDLE: begin
            tx_nxt = LINE_IDLE;
            if (in_valid && in_ready) begin
               load      = 1'b1;
               state_nxt = START;
               tx_nxt    = START_BIT;
            end
         end
         START: begin
            if (tick) begin
               state_nxt = DATA;
               tx_nxt    = shift_reg[0];
            end
         end
         DATA: begin
            if (tick) begin
               shift_en = 1'b1;
               if (idx == LAST_IDX) begin
                  state_nxt = STOP;
                  tx_nxt    = STOP_BIT;
               end else begin
                  tx_nxt = shifted[0];
               end
            end
         end
         STOP: begin
            if (tick) begin
               state_nxt = IDLE;
               tx_nxt    = LINE_IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
